// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle controller: state encodings,
// RV32 major opcodes, instruction classes and the counter width default.
package cpu_defs;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_ALU     = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_SYSTEM  = 3'd6
  } op_class_t;

endpackage

// File: rtl/opcode_classifier.sv
// Maps a 7-bit major opcode onto the instruction class that steers the FSM.
module opcode_classifier
  import cpu_defs::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_OP:     op_class = CLS_ALU;
      OPC_OP_IMM: op_class = CLS_ALU;
      OPC_BRANCH: op_class = CLS_BRANCH;
      OPC_JAL:    op_class = CLS_JAL;
      OPC_SYSTEM: op_class = CLS_SYSTEM;
      default:    op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, halt on
// SYSTEM or illegal opcodes, and a wrapping retired-instruction counter.
module multicycle_controller
  import cpu_defs::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             imem_ready,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             dmem_ready,
  output logic             load_en,
  output logic             imem_req,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  state_t           boundary_state;
  op_class_t        dec_class;

  opcode_classifier u_classifier (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  // Instruction boundary: run is only honoured here, never mid-instruction.
  assign boundary_state = run ? ST_FETCH : ST_IDLE;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    load_en   = 1'b0;
    imem_req  = 1'b0;
    alu_en    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_en = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op_d = opcode;
        case (dec_class)
          CLS_ILLEGAL: begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
          CLS_SYSTEM: state_d = ST_HALT;
          default:    state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        alu_en = 1'b1;
        if (op_q == OPC_LOAD || op_q == OPC_STORE) begin
          state_d = ST_MEM;
        end else if (op_q == OPC_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = branch_taken;
          retire   = 1'b1;
          state_d  = boundary_state;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OPC_STORE);
        if (dmem_ready) begin
          if (op_q == OPC_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = boundary_state;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        pc_src    = (op_q == OPC_JAL);
        retire    = 1'b1;
        state_d   = boundary_state;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 7'd0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (built with CNT_W=4 so the
// retired counter wrap is reachable).
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  // Control vector bit order:
  // {load_en, imem_req, alu_en, dmem_req, dmem_we, reg_write, pc_write, pc_src}
  localparam logic [7:0] C_NONE       = 8'b0000_0000;
  localparam logic [7:0] C_FETCH_LD   = 8'b1100_0000;
  localparam logic [7:0] C_FETCH_WAIT = 8'b0100_0000;
  localparam logic [7:0] C_EXEC       = 8'b0010_0000;
  localparam logic [7:0] C_BR_T       = 8'b0010_0011;
  localparam logic [7:0] C_BR_NT      = 8'b0010_0010;
  localparam logic [7:0] C_MEM_LD     = 8'b0001_0000;
  localparam logic [7:0] C_MEM_ST     = 8'b0001_1000;
  localparam logic [7:0] C_ST_DONE    = 8'b0001_1010;
  localparam logic [7:0] C_WB         = 8'b0000_0110;
  localparam logic [7:0] C_WB_JAL     = 8'b0000_0111;

  logic             clk = 1'b0;
  logic             reset, run, imem_ready, branch_taken, dmem_ready;
  logic [6:0]       opcode;
  logic             load_en, imem_req, alu_en, dmem_req, dmem_we;
  logic             reg_write, pc_write, pc_src, halted, illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic [7:0]       ctrl;

  int errors = 0;
  int checks = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .imem_ready   (imem_ready),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .dmem_ready   (dmem_ready),
    .load_en      (load_en),
    .imem_req     (imem_req),
    .alu_en       (alu_en),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .reg_write    (reg_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .state        (state),
    .halted       (halted),
    .illegal      (illegal),
    .retired      (retired)
  );

  assign ctrl = {load_en, imem_req, alu_en, dmem_req, dmem_we, reg_write, pc_write, pc_src};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [7:0] c);
    #1;
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_ctrl"}, 32'(ctrl), 32'(c));
  endtask

  task automatic check_retired(input string tag);
    check(tag, 32'(retired), 32'(exp_ret % 16));
  endtask

  task automatic reset_dut();
    reset        = 1'b1;
    run          = 1'b0;
    imem_ready   = 1'b0;
    branch_taken = 1'b0;
    dmem_ready   = 1'b0;
    opcode       = 7'd0;
    step();
    step();
    reset   = 1'b0;
    exp_ret = 0;
  endtask

  // From IDLE: fetch (with fetch_wait stall cycles), decode, and arrive in EXEC.
  task automatic start_instr(input logic [6:0] op, input int fetch_wait, input logic keep_run);
    opcode     = op;
    run        = 1'b1;
    imem_ready = 1'b0;
    step();
    if (!keep_run) run = 1'b0;
    for (int i = 0; i < fetch_wait; i++) begin
      expect_cyc("fetch_wait", 3'd1, C_FETCH_WAIT);
      step();
    end
    imem_ready = 1'b1;
    expect_cyc("fetch", 3'd1, C_FETCH_LD);
    step();
    expect_cyc("decode", 3'd2, C_NONE);
    step();
  endtask

  initial begin
    reset_dut();
    expect_cyc("reset", 3'd0, C_NONE);
    check("reset_retired", 32'(retired), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);

    // ALU op: FETCH, DECODE, EXEC, WB
    start_instr(7'b0110011, 0, 1'b0);
    expect_cyc("op_exec", 3'd3, C_EXEC);
    step();
    expect_cyc("op_wb", 3'd5, C_WB);
    step();
    exp_ret = 1;
    expect_cyc("op_done", 3'd0, C_NONE);
    check_retired("op_retired");

    // LOAD with fetch stall and three MEM wait cycles
    start_instr(7'b0000011, 2, 1'b0);
    expect_cyc("ld_exec", 3'd3, C_EXEC);
    step();
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_cyc("ld_mem_wait", 3'd4, C_MEM_LD);
      step();
    end
    dmem_ready = 1'b1;
    expect_cyc("ld_mem_rdy", 3'd4, C_MEM_LD);
    check_retired("ld_not_yet_retired");
    step();
    dmem_ready = 1'b0;
    expect_cyc("ld_wb", 3'd5, C_WB);
    step();
    exp_ret = 2;
    expect_cyc("ld_done", 3'd0, C_NONE);
    check_retired("ld_retired");

    // JAL selects the target in WB
    start_instr(7'b1101111, 0, 1'b0);
    expect_cyc("jal_exec", 3'd3, C_EXEC);
    step();
    expect_cyc("jal_wb", 3'd5, C_WB_JAL);
    step();
    exp_ret = 3;
    expect_cyc("jal_done", 3'd0, C_NONE);
    check_retired("jal_retired");

    // Taken branch with run held: straight back to FETCH
    start_instr(7'b1100011, 0, 1'b1);
    branch_taken = 1'b1;
    expect_cyc("br_taken_exec", 3'd3, C_BR_T);
    step();
    exp_ret = 4;
    expect_cyc("br_next_fetch", 3'd1, C_FETCH_LD);
    check_retired("br_taken_retired");
    run          = 1'b0;
    branch_taken = 1'b0;
    step();
    expect_cyc("br2_decode", 3'd2, C_NONE);
    step();
    expect_cyc("br_not_taken_exec", 3'd3, C_BR_NT);
    step();
    exp_ret = 5;
    expect_cyc("br2_done", 3'd0, C_NONE);
    check_retired("br_not_taken_retired");

    // STORE, run dropped during MEM: completes then goes IDLE
    start_instr(7'b0100011, 0, 1'b1);
    expect_cyc("st_exec", 3'd3, C_EXEC);
    step();
    dmem_ready = 1'b0;
    expect_cyc("st_mem_wait", 3'd4, C_MEM_ST);
    step();
    run        = 1'b0;
    dmem_ready = 1'b1;
    expect_cyc("st_mem_rdy", 3'd4, C_ST_DONE);
    step();
    dmem_ready = 1'b0;
    exp_ret = 6;
    expect_cyc("st_done", 3'd0, C_NONE);
    check_retired("st_retired");

    // Reset while stalled in FETCH
    run        = 1'b1;
    imem_ready = 1'b0;
    step();
    expect_cyc("rst_fetch", 3'd1, C_FETCH_WAIT);
    reset = 1'b1;
    step();
    exp_ret = 0;
    expect_cyc("rst_in_fetch", 3'd0, C_NONE);
    check_retired("rst_in_fetch_retired");
    reset = 1'b0;
    run   = 1'b0;
    step();

    // Counter wrap: 16 back-to-back branches on a 4-bit counter
    opcode     = 7'b1100011;
    imem_ready = 1'b1;
    run        = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      branch_taken = i[0];
      step();
      step();
      step();
      exp_ret++;
      if (i == 14) begin
        #1;
        check_retired("wrap_at_15");
      end
    end
    #1;
    check("wrap_to_0", 32'(retired), 32'd0);
    check("wrap_state", 32'(state), 32'd1);

    // Illegal opcode halts with illegal set; run is ignored in HALT
    reset_dut();
    opcode     = 7'b1111111;
    imem_ready = 1'b1;
    run        = 1'b1;
    step();
    step();
    expect_cyc("ill_decode", 3'd2, C_NONE);
    step();
    expect_cyc("ill_halt", 3'd6, C_NONE);
    check("ill_halted", 32'(halted), 32'd1);
    check("ill_illegal", 32'(illegal), 32'd1);
    for (int i = 0; i < 10; i++) begin
      run = ~run;
      step();
    end
    expect_cyc("ill_stays", 3'd6, C_NONE);
    check("ill_held", 32'(illegal), 32'd1);
    check("ill_no_retire", 32'(retired), 32'd0);
    reset_dut();
    expect_cyc("ill_reset", 3'd0, C_NONE);
    check("ill_reset_halted", 32'(halted), 32'd0);
    check("ill_reset_illegal", 32'(illegal), 32'd0);

    // SYSTEM halts without flagging illegal
    opcode     = 7'b1110011;
    imem_ready = 1'b1;
    run        = 1'b1;
    step();
    step();
    step();
    expect_cyc("sys_halt", 3'd6, C_NONE);
    check("sys_halted", 32'(halted), 32'd1);
    check("sys_illegal", 32'(illegal), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
